// File: rtl/mem_stage.sv
// MIPS MEM stage: word RAM with programmable multi-cycle access latency,
// branch resolution, and the MEM/WB pipeline register.
module mem_stage #(
  parameter int ADDR_LOG2 = 8,
  parameter int LATENCY   = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [1:0]  wb_ctlout,
  input  logic [2:0]  m_ctlout,
  input  logic [29:0] add_result,
  input  logic        zero,
  input  logic [31:0] alu_result,
  input  logic [31:0] rdata2out,
  input  logic [4:0]  five_bit_muxout,
  output logic        data_hit,
  output logic        pcsrc,
  output logic [29:0] branch_target,
  output logic [1:0]  memwb_wb,
  output logic [31:0] memwb_rdata,
  output logic [31:0] memwb_alu,
  output logic [4:0]  memwb_reg,
  output logic [15:0] stall_count
);

  typedef enum logic {IDLE, BUSY} state_t;

  localparam bit         HAS_LAT = (LATENCY > 0);
  localparam logic [3:0] LAT_M1  = HAS_LAT ? 4'(LATENCY - 1) : 4'd0;
  localparam int         DEPTH   = 1 << ADDR_LOG2;

  state_t                 state, state_nxt;
  logic [3:0]             cnt, cnt_nxt;
  logic                   mem_op;
  logic [ADDR_LOG2-1:0]   idx;
  logic [31:0]            rd_word;
  logic [31:0]            ram [0:DEPTH-1];

  assign mem_op        = m_ctlout[1] | m_ctlout[0];
  assign idx           = alu_result[ADDR_LOG2+1:2];
  assign rd_word       = ram[idx];
  assign pcsrc         = m_ctlout[2] & zero;
  assign branch_target = add_result;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= 4'd0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    data_hit  = 1'b1;
    case (state)
      IDLE: if (mem_op && HAS_LAT) begin
        data_hit  = 1'b0;
        state_nxt = BUSY;
        cnt_nxt   = LAT_M1;
      end
      BUSY: if (cnt != 4'd0) begin
        data_hit = 1'b0;
        cnt_nxt  = cnt - 4'd1;
      end else begin
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
    // Reset never stalls upstream.
    if (!rst_n) data_hit = 1'b1;
  end

  // RAM is deliberately not reset; a store only lands on its completion edge.
  always_ff @(posedge clk) begin
    if (rst_n && data_hit && m_ctlout[0]) ram[idx] <= rdata2out;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      memwb_wb    <= 2'b00;
      memwb_rdata <= 32'd0;
      memwb_alu   <= 32'd0;
      memwb_reg   <= 5'd0;
    end else if (data_hit) begin
      memwb_wb    <= wb_ctlout;
      memwb_rdata <= m_ctlout[1] ? rd_word : 32'd0;
      memwb_alu   <= alu_result;
      memwb_reg   <= five_bit_muxout;
    end else begin
      // Bubble: kill writeback controls so a stalled op is not retired twice.
      memwb_wb <= 2'b00;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n)                                   stall_count <= 16'd0;
    else if (!data_hit && stall_count != 16'hFFFF) stall_count <= stall_count + 16'd1;
  end

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: table of single-cycle ops plus hand
// sequences for stalls, bubbles, wrap-around and reset mid-access.
module tb_mem_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  wb_ctlout;
  logic [2:0]  m_ctlout;
  logic [29:0] add_result;
  logic        zero;
  logic [31:0] alu_result;
  logic [31:0] rdata2out;
  logic [4:0]  five_bit_muxout;
  logic        data_hit;
  logic        pcsrc;
  logic [29:0] branch_target;
  logic [1:0]  memwb_wb;
  logic [31:0] memwb_rdata;
  logic [31:0] memwb_alu;
  logic [4:0]  memwb_reg;
  logic [15:0] stall_count;

  int n_total = 0;
  int n_pass  = 0;

  mem_stage #(.ADDR_LOG2(8), .LATENCY(2)) dut (
    .clk(clk), .rst_n(rst_n), .wb_ctlout(wb_ctlout), .m_ctlout(m_ctlout),
    .add_result(add_result), .zero(zero), .alu_result(alu_result),
    .rdata2out(rdata2out), .five_bit_muxout(five_bit_muxout),
    .data_hit(data_hit), .pcsrc(pcsrc), .branch_target(branch_target),
    .memwb_wb(memwb_wb), .memwb_rdata(memwb_rdata), .memwb_alu(memwb_alu),
    .memwb_reg(memwb_reg), .stall_count(stall_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  wb;
    logic [2:0]  m;
    logic [29:0] add;
    logic        zero;
    logic [31:0] alu;
    logic [4:0]  rg;
    logic        e_pcsrc;
    logic [1:0]  e_wb;
    logic [31:0] e_alu;
    logic [4:0]  e_reg;
  } vec_t;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h want %0h", nm, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [1:0] wb, input logic [2:0] m, input logic [31:0] alu,
                       input logic [31:0] wd, input logic [4:0] rg);
    wb_ctlout = wb; m_ctlout = m; alu_result = alu; rdata2out = wd; five_bit_muxout = rg;
    add_result = 30'd0; zero = 1'b0;
  endtask

  // Apply a memory op, count stall cycles (checking the bubble on each stall
  // edge) and return just after the completion edge.
  task automatic run_op(input logic [1:0] wb, input logic [2:0] m, input logic [31:0] alu,
                        input logic [31:0] wd, input logic [4:0] rg, output int stalls);
    logic [31:0] prev_alu;
    prev_alu = memwb_alu;
    drive(wb, m, alu, wd, rg);
    stalls = 0;
    #1;
    while (data_hit === 1'b0 && stalls < 40) begin
      step();
      stalls++;
      chk("bubble_wb", memwb_wb, 2'b00);
      chk("bubble_alu", memwb_alu, prev_alu);
    end
    chk("stall_bound", stalls < 40, 1'b1);
    step();
  endtask

  vec_t vt[4];
  int   st;

  initial begin
    vt[0] = '{wb:2'b10, m:3'b000, add:30'h0,   zero:1'b0, alu:32'd10,       rg:5'd10,
              e_pcsrc:1'b0, e_wb:2'b10, e_alu:32'd10,       e_reg:5'd10};
    vt[1] = '{wb:2'b00, m:3'b100, add:30'h123, zero:1'b1, alu:32'd7,        rg:5'd3,
              e_pcsrc:1'b1, e_wb:2'b00, e_alu:32'd7,        e_reg:5'd3};
    vt[2] = '{wb:2'b00, m:3'b100, add:30'h123, zero:1'b0, alu:32'd8,        rg:5'd4,
              e_pcsrc:1'b0, e_wb:2'b00, e_alu:32'd8,        e_reg:5'd4};
    vt[3] = '{wb:2'b10, m:3'b000, add:30'h3FFFFFFF, zero:1'b1, alu:32'hFFFFFFFF, rg:5'd31,
              e_pcsrc:1'b0, e_wb:2'b10, e_alu:32'hFFFFFFFF, e_reg:5'd31};

    // Reset held for two edges with a load present: no stall while in reset.
    rst_n = 1'b0;
    drive(2'b11, 3'b010, 32'h40, 32'd0, 5'd1);
    step();
    step();
    chk("rst_hit", data_hit, 1'b1);
    chk("rst_wb", memwb_wb, 2'b00);
    chk("rst_alu", memwb_alu, 32'd0);
    chk("rst_reg", memwb_reg, 5'd0);
    chk("rst_rdata", memwb_rdata, 32'd0);
    chk("rst_stall", stall_count, 16'd0);

    drive(2'b00, 3'b000, 32'd0, 32'd0, 5'd0);
    rst_n = 1'b1;
    step();

    for (int i = 0; i < 4; i++) begin
      wb_ctlout = vt[i].wb; m_ctlout = vt[i].m; add_result = vt[i].add; zero = vt[i].zero;
      alu_result = vt[i].alu; five_bit_muxout = vt[i].rg; rdata2out = 32'hA5A5A5A5;
      #1;
      chk("vec_hit", data_hit, 1'b1);
      chk("vec_pcsrc", pcsrc, vt[i].e_pcsrc);
      chk("vec_target", branch_target, vt[i].add);
      step();
      chk("vec_wb", memwb_wb, vt[i].e_wb);
      chk("vec_alu", memwb_alu, vt[i].e_alu);
      chk("vec_reg", memwb_reg, vt[i].e_reg);
      chk("vec_rdata", memwb_rdata, 32'd0);
    end
    chk("alu_nostall", stall_count, 16'd0);

    // Store then back-to-back load, same address.
    run_op(2'b00, 3'b001, 32'h40, 32'hDEADBEEF, 5'd0, st);
    chk("st_stalls", st, 2);
    chk("st_count", stall_count, 16'd2);
    run_op(2'b11, 3'b010, 32'h40, 32'd0, 5'd9, st);
    chk("ld_stalls", st, 2);
    chk("ld_count", stall_count, 16'd4);
    chk("ld_rdata", memwb_rdata, 32'hDEADBEEF);
    chk("ld_wb", memwb_wb, 2'b11);
    chk("ld_reg", memwb_reg, 5'd9);

    // Byte offset bits are ignored.
    run_op(2'b11, 3'b010, 32'h43, 32'd0, 5'd2, st);
    chk("offs_rdata", memwb_rdata, 32'hDEADBEEF);

    // Read-before-write when both MemRead and MemWrite are set.
    run_op(2'b11, 3'b011, 32'h40, 32'h11111111, 5'd3, st);
    chk("rbw_rdata", memwb_rdata, 32'hDEADBEEF);
    run_op(2'b11, 3'b010, 32'h40, 32'd0, 5'd3, st);
    chk("rbw_new", memwb_rdata, 32'h11111111);

    // Wrap-around: 0x400 aliases word 0.
    run_op(2'b00, 3'b001, 32'h400, 32'd5, 5'd0, st);
    run_op(2'b11, 3'b010, 32'h0, 32'd0, 5'd4, st);
    chk("wrap_rdata", memwb_rdata, 32'd5);

    // Reset during the second stall cycle of a store aborts it.
    run_op(2'b00, 3'b001, 32'h80, 32'h12345678, 5'd0, st);
    drive(2'b00, 3'b001, 32'h80, 32'hCAFEF00D, 5'd0);
    #1;
    chk("abort_stall1", data_hit, 1'b0);
    step();
    chk("abort_stall2", data_hit, 1'b0);
    rst_n = 1'b0;
    #1;
    chk("abort_hit_rst", data_hit, 1'b1);
    step();
    chk("abort_alu", memwb_alu, 32'd0);
    chk("abort_count", stall_count, 16'd0);
    rst_n = 1'b1;
    run_op(2'b11, 3'b010, 32'h80, 32'd0, 5'd6, st);
    chk("abort_ld_stalls", st, 2);
    chk("abort_rdata", memwb_rdata, 32'h12345678);
    chk("abort_ld_count", stall_count, 16'd2);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/mem_stage.md
# mem_stage

Memory-access stage of the 5-stage MIPS pipeline. It consumes the EX/MEM pipeline register outputs, performs data-memory loads and stores against an internal word RAM with a programmable multi-cycle access latency, and resolves branches. It holds the MEM/WB pipeline register. While an access is in flight it deasserts `data_hit`, which stalls EX_MEM and everything upstream.

## Interface
- `ADDR_LOG2`, default 8: data RAM depth is 2^ADDR_LOG2 32-bit words.
- `LATENCY`, default 2, legal range 0..15: stall cycles per load or store.

Ports:
- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  reset, synchronous, active-low.
- `wb_ctlout`  in  2  bit 1 is RegWrite, bit 0 is MemtoReg.
- `m_ctlout`  in  3  bit 2 is Branch, bit 1 is MemRead, bit 0 is MemWrite.
- `add_result`  in  30  branch target word address.
- `zero`  in  1  ALU zero flag.
- `alu_result`  in  32  ALU result, which is the byte address for loads and stores.
- `rdata2out`  in  32  store data.
- `five_bit_muxout`  in  5  destination register.
- `data_hit`  out  1  1 means this stage completes this cycle; 0 means stall upstream.
- `pcsrc`  out  1  branch taken.
- `branch_target`  out  30  equals `add_result`.
- `memwb_wb`  out  2  registered WB controls.
- `memwb_rdata`  out  32  registered load data.
- `memwb_alu`  out  32  registered ALU result.
- `memwb_reg`  out  5  registered destination register.
- `stall_count`  out  16  saturating count of stall cycles.

## Operation
- A memory op is present when `m_ctlout[1] | m_ctlout[0]`.
- Word index is `alu_result[ADDR_LOG2+1:2]`.
  - Bits [1:0] are ignored.
  - Higher bits are ignored, so addresses wrap modulo the RAM size.
- FSM states:
  - IDLE: if a memory op is present and LATENCY>0, load `cnt=LATENCY-1` and go to BUSY. Otherwise stay in IDLE.
  - BUSY: if `cnt!=0`, decrement `cnt`. If `cnt==0`, complete the access and go to IDLE.
- `data_hit` is combinational:
  - 0 in IDLE while a memory op is present and LATENCY>0.
  - 0 in BUSY while `cnt!=0`.
  - 1 otherwise, including whenever `rst_n=0`.
- Completion edge is any rising edge with `data_hit=1` and `rst_n=1`:
  - A store writes `rdata2out` to RAM.
  - The MEM/WB register loads `memwb_wb=wb_ctlout`, `memwb_alu=alu_result`, `memwb_reg=five_bit_muxout`, and `memwb_rdata` = RAM[index] for a load, else 0.
- MemRead and MemWrite both set: the store is performed and `memwb_rdata` returns the pre-write contents (read-before-write).
- Stall edge (`data_hit=0`): the MEM/WB register takes a bubble. `memwb_wb=2'b00`, other MEM/WB fields hold. This prevents a duplicate writeback.
- `pcsrc = m_ctlout[2] & zero`, combinational and independent of the FSM.
- `stall_count` increments on every edge with `data_hit=0` and saturates at 16'hFFFF.
- Inputs must hold stable while `data_hit=0`; EX_MEM guarantees this.

## Timing
- Reset (`rst_n=0` at an edge):
  - FSM goes to IDLE and `cnt=0`.
  - All `memwb_*` outputs and `stall_count` go to 0.
  - An in-flight store is dropped and RAM is not written.
  - RAM contents are not reset.
- Reset asserted mid-access: the access is aborted. After release, the op still present on the inputs restarts with the full LATENCY.
- A load or store costs LATENCY stall cycles plus one completion cycle. MEM/WB shows the result one edge after completion.
- LATENCY=0: every op completes in a single cycle and `data_hit` stays 1.
- Back-to-back memory ops: the FSM returns to IDLE on the completion edge, and the next op starts its own stall in the following cycle with no extra idle cycle.
- Non-memory ops: zero stall, latched on the next edge.
- A store followed immediately by a load to the same address: the load returns the newly stored value.

## Test plan
- Reset and ALU op: hold `rst_n=0` for 2 edges, then release. Apply `wb=2'b10`, `m=0`, `alu=10`, `reg=10`. Required: `data_hit=1` and, after one edge, `memwb_wb=2'b10`, `memwb_alu=10`, `memwb_reg=10`, `memwb_rdata=0`.
- Store then load, LATENCY=2:
  - Store 32'hDEADBEEF at address 0x40. Required: `data_hit` low for exactly 2 cycles and `stall_count=2`.
  - Then load from 0x40 with `wb=2'b11`. Required: 2 further stall cycles and `memwb_rdata=32'hDEADBEEF`.
- Bubble: during a load stall, the MEM/WB register holds `memwb_wb=2'b00` on every stall edge and `memwb_alu` is unchanged.
- Wrap-around, ADDR_LOG2=8: store 5 to address 0x400, then load from address 0x000. Required: 5 is returned.
- Reset mid-access: assert `rst_n=0` during the store's second stall cycle. Required: outputs are cleared and a subsequent load of that address does not return the new data.
- Branch: apply `m=3'b100`, `zero=1`, `add_result=30'h123`. Required: `pcsrc=1`, `branch_target=30'h123`, `data_hit=1`. With `zero=0`, required: `pcsrc=0`.
